// File: rtl/alu_op_sequencer_if.sv
// Request, unit-side and result-side bus of the ALU operation sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface alu_op_sequencer_if #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16
);
  logic                      IN_VALID;
  logic                      IN_READY;
  logic [IN_DATA_WIDTH-1:0]  IN_A;
  logic [IN_DATA_WIDTH-1:0]  IN_B;
  logic [3:0]                IN_FUN;

  logic [IN_DATA_WIDTH-1:0]  A;
  logic [IN_DATA_WIDTH-1:0]  B;
  logic [1:0]                FUN_SEL;
  logic                      ARITH_Enable;
  logic                      LOGIC_Enable;
  logic                      CMP_Enable;
  logic                      SHIFT_Enable;

  logic [OUT_DATA_WIDTH-1:0] ARITH_OUT;
  logic [OUT_DATA_WIDTH-1:0] LOGIC_OUT;
  logic [OUT_DATA_WIDTH-1:0] CMP_OUT;
  logic [OUT_DATA_WIDTH-1:0] SHIFT_OUT;
  logic                      ARITH_Flag;
  logic                      LOGIC_Flag;
  logic                      CMP_Flag;
  logic                      SHIFT_Flag;

  logic [OUT_DATA_WIDTH-1:0] RESULT;
  logic                      RESULT_VALID;
  logic                      RESULT_ERR;
  logic                      RESULT_READY;

  modport slave (
    input  IN_VALID, IN_A, IN_B, IN_FUN,
    output IN_READY,
    output A, B, FUN_SEL, ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable,
    input  ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT,
    input  ARITH_Flag, LOGIC_Flag, CMP_Flag, SHIFT_Flag,
    output RESULT, RESULT_VALID, RESULT_ERR,
    input  RESULT_READY
  );

  modport master (
    output IN_VALID, IN_A, IN_B, IN_FUN,
    input  IN_READY,
    input  A, B, FUN_SEL, ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable,
    output ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT,
    output ARITH_Flag, LOGIC_Flag, CMP_Flag, SHIFT_Flag,
    input  RESULT, RESULT_VALID, RESULT_ERR,
    output RESULT_READY
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time through four external execution units:
// accept operands, pulse the selected unit's enable, wait for its flag (bounded), hold the result.
module alu_op_sequencer #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int WAIT_LIMIT     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_LIMIT - 1);

  state_e                    state_q,  state_d;
  logic [3:0]                cnt_q,    cnt_d;
  logic [IN_DATA_WIDTH-1:0]  a_q,      a_d;
  logic [IN_DATA_WIDTH-1:0]  b_q,      b_d;
  logic [3:0]                op_q,     op_d;
  logic [OUT_DATA_WIDTH-1:0] result_q, result_d;
  logic                      err_q,    err_d;

  logic                      sel_flag_s;
  logic [OUT_DATA_WIDTH-1:0] sel_out_s;

  // Only the unit named by the latched op may complete the operation.
  always_comb begin
    sel_flag_s = 1'b0;
    sel_out_s  = '0;
    case (op_q[3:2])
      2'b00: begin
        sel_flag_s = bus.ARITH_Flag;
        sel_out_s  = bus.ARITH_OUT;
      end
      2'b01: begin
        sel_flag_s = bus.LOGIC_Flag;
        sel_out_s  = bus.LOGIC_OUT;
      end
      2'b10: begin
        sel_flag_s = bus.CMP_Flag;
        sel_out_s  = bus.CMP_OUT;
      end
      2'b11: begin
        sel_flag_s = bus.SHIFT_Flag;
        sel_out_s  = bus.SHIFT_OUT;
      end
      default: begin
        sel_flag_s = 1'b0;
        sel_out_s  = '0;
      end
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          a_d     = bus.IN_A;
          b_d     = bus.IN_B;
          op_d    = bus.IN_FUN;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 4'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A flag in the last permitted cycle still counts as a normal completion.
        if (sel_flag_s) begin
          result_d = sel_out_s;
          err_d    = 1'b0;
          state_d  = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_HOLD;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.RESULT_READY) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 4'd0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Handshake and enables depend on registers only, never on inputs.
  assign bus.IN_READY     = (state_q == S_IDLE);
  assign bus.RESULT_VALID = (state_q == S_HOLD);
  assign bus.ARITH_Enable = (state_q == S_ISSUE) && (op_q[3:2] == 2'b00);
  assign bus.LOGIC_Enable = (state_q == S_ISSUE) && (op_q[3:2] == 2'b01);
  assign bus.CMP_Enable   = (state_q == S_ISSUE) && (op_q[3:2] == 2'b10);
  assign bus.SHIFT_Enable = (state_q == S_ISSUE) && (op_q[3:2] == 2'b11);
  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.FUN_SEL      = op_q[1:0];
  assign bus.RESULT       = result_q;
  assign bus.RESULT_ERR   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: the driver plays the execution units and
// records the expected per-cycle outputs as a transaction timeline; one process compares.
module tb_alu_op_sequencer;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int WL = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  alu_op_sequencer_if #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW)) bus ();

  alu_op_sequencer #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .WAIT_LIMIT(WL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic          check_on = 1'b0;
  logic          exp_ready, exp_valid, exp_err;
  logic [3:0]    exp_en;
  logic [OW-1:0] exp_res;
  logic [IW-1:0] exp_a, exp_b;
  logic [1:0]    exp_fun;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the timeline, away from the active edge.
  always @(negedge CLK) begin
    if (check_on) begin
      chk("in_ready", 32'(bus.IN_READY), 32'(exp_ready));
      chk("enables", 32'({bus.SHIFT_Enable, bus.CMP_Enable, bus.LOGIC_Enable, bus.ARITH_Enable}), 32'(exp_en));
      chk("result_valid", 32'(bus.RESULT_VALID), 32'(exp_valid));
      chk("result", 32'(bus.RESULT), 32'(exp_res));
      chk("result_err", 32'(bus.RESULT_ERR), 32'(exp_err));
      chk("a", 32'(bus.A), 32'(exp_a));
      chk("b", 32'(bus.B), 32'(exp_b));
      chk("fun_sel", 32'(bus.FUN_SEL), 32'(exp_fun));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_reset();
    exp_ready = 1'b1; exp_valid = 1'b0; exp_err = 1'b0; exp_en = 4'd0;
    exp_res = '0; exp_a = '0; exp_b = '0; exp_fun = 2'd0;
  endtask

  // Behavioural unit functions used as the value a unit returns.
  function automatic logic [OW-1:0] unit_val(input int u, input logic [1:0] f,
                                             input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [OW-1:0] r;
    case (u)
      0: r = (f == 2'd0) ? a + b : (f == 2'd1) ? a - b : (f == 2'd2) ? a * b : a + 16'd1;
      1: r = (f == 2'd0) ? a & b : (f == 2'd1) ? a | b : (f == 2'd2) ? a ^ b : ~a;
      2: r = (f == 2'd0) ? 16'(a == b) : (f == 2'd1) ? 16'(a < b) : (f == 2'd2) ? ((a > b) ? 16'd2 : 16'd0) : 16'(a != b);
      default: r = (f[0]) ? a >> b[3:0] : a << b[3:0];
    endcase
    return r;
  endfunction

  // Random unit activity and junk requests; the DUT must ignore all of it unless selected.
  task automatic noise(input logic bv);
    bus.ARITH_OUT = OW'($urandom); bus.LOGIC_OUT = OW'($urandom);
    bus.CMP_OUT   = OW'($urandom); bus.SHIFT_OUT = OW'($urandom);
    bus.ARITH_Flag = 1'($urandom); bus.LOGIC_Flag = 1'($urandom);
    bus.CMP_Flag   = 1'($urandom); bus.SHIFT_Flag = 1'($urandom);
    bus.IN_VALID = bv ? 1'b1 : 1'($urandom);
    bus.IN_A = IW'($urandom); bus.IN_B = IW'($urandom); bus.IN_FUN = 4'($urandom);
    bus.RESULT_READY = 1'($urandom);
  endtask

  task automatic set_unit(input int u, input logic flag, input logic [OW-1:0] v);
    case (u)
      0: begin bus.ARITH_Flag = flag; bus.ARITH_OUT = v; end
      1: begin bus.LOGIC_Flag = flag; bus.LOGIC_OUT = v; end
      2: begin bus.CMP_Flag   = flag; bus.CMP_OUT   = v; end
      default: begin bus.SHIFT_Flag = flag; bus.SHIFT_OUT = v; end
    endcase
  endtask

  task automatic idle_cycle();
    noise(1'b0);
    bus.IN_VALID = 1'b0;
    exp_ready = 1'b1; exp_en = 4'd0; exp_valid = 1'b0;
    step();
  endtask

  // One transaction: unit answers in WAIT cycle d-1 (d=0: never), result held h cycles.
  task automatic run_op(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [3:0] fun,
                        input int d, input int h, input logic [OW-1:0] rv,
                        input logic bv, input int wrong_at);
    int u;
    logic hit;
    u = int'(fun[3:2]);
    hit = 1'b0;
    noise(1'b0);
    bus.IN_VALID = 1'b1; bus.IN_A = a; bus.IN_B = b; bus.IN_FUN = fun;
    exp_ready = 1'b1; exp_en = 4'd0; exp_valid = 1'b0;
    step();
    exp_a = a; exp_b = b; exp_fun = fun[1:0];
    noise(bv);
    exp_ready = 1'b0; exp_en = 4'(1 << u);
    step();
    exp_en = 4'd0;
    for (int w = 0; w < WL; w++) begin
      noise(bv);
      hit = (d != 0) && (w == d - 1);
      set_unit(u, hit, hit ? rv : OW'($urandom));
      if (w == wrong_at) set_unit((u + 1) % 4, 1'b1, OW'($urandom));
      step();
      if (hit) break;
    end
    exp_res = hit ? rv : '0;
    exp_err = !hit;
    exp_valid = 1'b1;
    for (int k = 0; k <= h; k++) begin
      noise(bv);
      bus.RESULT_READY = (k == h);
      step();
    end
    exp_valid = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Reset pulsed in WAIT; the late unit answer must be ignored.
  task automatic reset_mid_wait(input logic [3:0] fun);
    int u;
    u = int'(fun[3:2]);
    noise(1'b0);
    bus.IN_VALID = 1'b1; bus.IN_A = 16'h1234; bus.IN_B = 16'h00ff; bus.IN_FUN = fun;
    exp_ready = 1'b1; exp_en = 4'd0; exp_valid = 1'b0;
    step();
    exp_a = 16'h1234; exp_b = 16'h00ff; exp_fun = fun[1:0];
    noise(1'b0); bus.IN_VALID = 1'b0;
    exp_ready = 1'b0; exp_en = 4'(1 << u);
    step();
    exp_en = 4'd0;
    for (int w = 0; w < 2; w++) begin
      noise(1'b0); bus.IN_VALID = 1'b0; set_unit(u, 1'b0, OW'($urandom));
      step();
    end
    RST = 1'b0;
    exp_reset();
    bus.IN_VALID = 1'b0;
    step();
    RST = 1'b1;
    for (int w = 0; w < 3; w++) begin
      noise(1'b0);
      bus.IN_VALID = 1'b0;
      set_unit(u, 1'b1, 16'h5a5a);
      step();
    end
  endtask

  initial begin
    logic [IW-1:0] ra, rb;
    logic [3:0]    rf;
    int            rd;
    RST = 1'b1;
    bus.IN_VALID = 1'b0; bus.IN_A = '0; bus.IN_B = '0; bus.IN_FUN = 4'd0;
    bus.ARITH_OUT = '0; bus.LOGIC_OUT = '0; bus.CMP_OUT = '0; bus.SHIFT_OUT = '0;
    bus.ARITH_Flag = 1'b0; bus.LOGIC_Flag = 1'b0; bus.CMP_Flag = 1'b0; bus.SHIFT_Flag = 1'b0;
    bus.RESULT_READY = 1'b0;
    exp_reset();
    #2 RST = 1'b0;
    check_on = 1'b1;
    step();
    step();
    RST = 1'b1;
    idle_cycle();

    // CMP greater: one-cycle unit response.
    run_op(16'd5, 16'd3, 4'b1010, 1, 0, 16'h0002, 1'b0, -1);
    chk("cmp_literal_result", 32'(bus.RESULT), 32'h0002);
    chk("cmp_literal_err", 32'(bus.RESULT_ERR), 32'h0);
    idle_cycle();

    // Wrong-unit flag first, selected ARITH three cycles later.
    run_op(16'd6, 16'd2, 4'b0001, 4, 0, 16'h0008, 1'b0, 0);
    chk("wrong_unit_literal_result", 32'(bus.RESULT), 32'h0008);

    // Timeout on SHIFT.
    run_op(16'h00f0, 16'd4, 4'b1111, 0, 0, 16'h0000, 1'b0, -1);
    chk("timeout_literal_result", 32'(bus.RESULT), 32'h0);
    chk("timeout_literal_err", 32'(bus.RESULT_ERR), 32'h1);

    // Flag in the final WAIT cycle beats the timeout.
    run_op(16'h0003, 16'h0004, 4'b0110, WL, 0, 16'h0007, 1'b0, -1);
    chk("flag_wins_literal_err", 32'(bus.RESULT_ERR), 32'h0);

    // Backpressure with IN_VALID held high, then a following request.
    run_op(16'h0101, 16'h0202, 4'b0100, 2, 10, 16'h0303, 1'b1, -1);
    run_op(16'h0011, 16'h0022, 4'b1001, 1, 0, unit_val(2, 2'b01, 16'h0011, 16'h0022), 1'b1, -1);

    // Back-to-back, one per unit, READY asserted at once.
    for (int u = 0; u < 4; u++) begin
      ra = IW'($urandom); rb = IW'($urandom); rf = {2'(u), 2'($urandom)};
      run_op(ra, rb, rf, 1, 0, unit_val(u, rf[1:0], ra, rb), 1'b0, -1);
    end

    reset_mid_wait(4'b1000);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      ra = IW'($urandom); rb = IW'($urandom); rf = 4'($urandom);
      rd = int'($urandom_range(0, WL));
      run_op(ra, rb, rf, rd, int'($urandom_range(0, 3)),
             unit_val(int'(rf[3:2]), rf[1:0], ra, rb), 1'($urandom), -1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    check_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
